// File: rtl/aes_round_sequencer_pkg.sv
// aes_seq_pkg: phase/mode encodings and round-count helper shared by the AES round sequencer.
package aes_seq_pkg;
    localparam int NR_MAX = 14;
    typedef enum logic [1:0] {PH_IDLE, PH_ENC, PH_DEC, PH_DONE} phase_t;
    typedef enum logic [1:0] {MODE_128, MODE_192, MODE_256, MODE_RSVD} mode_t;
    function automatic logic [1:0] map_mode(input logic [1:0] m);
        return m == 2'(MODE_RSVD) ? 2'(MODE_128) : m;
    endfunction
    function automatic logic [3:0] nr(input logic [1:0] m, input int base = 10, input int stp = 2);
        return 4'(base + stp * int'(map_mode(m)));
    endfunction
endpackage

// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if: run control inputs and round/status outputs of the round sequencer.
interface aes_round_sequencer_if #(parameter int CNT_W = 5);
    import aes_seq_pkg::*;
    logic start;
    logic step;
    logic [1:0] mode;
    logic dec_match;
    phase_t phase;
    logic busy;
    logic [1:0] mode_q;
    logic [CNT_W-1:0] round;
    logic [3:0] enc_round;
    logic [3:0] dec_round;
    logic [3:0] round_units;
    logic [3:0] round_tens;
    logic done;
    logic pass;
    modport master(
        output start, step, mode, dec_match,
        input phase, busy, mode_q, round, enc_round, dec_round, round_units, round_tens, done, pass
    );
    modport slave(
        input start, step, mode, dec_match,
        output phase, busy, mode_q, round, enc_round, dec_round, round_units, round_tens, done, pass
    );
endinterface

// File: rtl/aes_round_sequencer_bcd_counter2.sv
// bcd_counter2: two-digit BCD incrementer with synchronous clear and increment enable.
module bcd_counter2 (
    input logic clk,
    input logic rst_n,
    input logic clr,
    input logic inc,
    output logic [3:0] units,
    output logic [3:0] tens
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            units <= '0;
            tens <= '0;
        end else if (clr) begin
            units <= '0;
            tens <= '0;
        end else if (inc) begin
            units <= units == 4'd9 ? 4'd0 : units + 4'd1;
            tens <= units == 4'd9 ? tens + 4'd1 : tens;
        end
    end
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: encrypt-then-decrypt round sequencer with BCD round copy and pass latch.
// Optional AES_SEQ_AUTORUN_EN adds a prescaler that issues a step every AUTO_DIV busy cycles.
module aes_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int BASE_ROUNDS = 10,
    parameter int ROUND_STEP = 2,
    parameter int CNT_W = 5
`ifdef AES_SEQ_AUTORUN_EN
    , parameter int AUTO_DIV = 4
`endif
) (
    input logic KEY,
    input logic rst_n,
    aes_round_sequencer_if.slave bus
);
    phase_t phase_q, phase_d;
    logic [1:0] mode_r;
    logic [CNT_W-1:0] round_r;
    logic [3:0] enc_r, dec_r, nr_c, units, tens;
    logic busy_r, done_r, pass_r;
    logic in_run, start_ok, step_any, step_ok, last_enc, last_dec;

    assign in_run = phase_q == PH_ENC || phase_q == PH_DEC;
`ifdef AES_SEQ_AUTORUN_EN
    localparam int PW = AUTO_DIV > 1 ? $clog2(AUTO_DIV) : 1;
    logic [PW-1:0] pre_q;
    logic auto_step;
    assign auto_step = in_run && pre_q == PW'(AUTO_DIV - 1);
    // Held at zero outside a run, so an accepted start always begins a fresh period.
    always_ff @(posedge KEY or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else if (!in_run || auto_step) pre_q <= '0;
        else pre_q <= pre_q + PW'(1);
    end
    assign step_any = bus.step | auto_step;
`else
    assign step_any = bus.step;
`endif

    always_comb begin
        nr_c = nr(mode_r, BASE_ROUNDS, ROUND_STEP);
        start_ok = bus.start && !in_run;
        step_ok = step_any && in_run;
        last_enc = phase_q == PH_ENC && enc_r == nr_c;
        last_dec = phase_q == PH_DEC && dec_r == nr_c;
        phase_d = start_ok ? PH_ENC : !step_ok ? phase_q : last_enc ? PH_DEC : last_dec ? PH_DONE : phase_q;
    end

    always_ff @(posedge KEY or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            mode_r <= '0;
            round_r <= '0;
            enc_r <= '0;
            dec_r <= '0;
        end else begin
            phase_q <= phase_d;
            busy_r <= phase_d == PH_ENC || phase_d == PH_DEC;
            done_r <= step_ok && last_dec;
            if (start_ok) begin
                mode_r <= map_mode(bus.mode);
                round_r <= '0;
                enc_r <= '0;
                dec_r <= '0;
                pass_r <= 1'b0;
            end else if (step_ok && phase_q == PH_ENC) begin
                enc_r <= last_enc ? enc_r : enc_r + 4'd1;
                round_r <= round_r + CNT_W'(1);
            end else if (step_ok && last_dec) begin
                pass_r <= bus.dec_match;
            end else if (step_ok) begin
                dec_r <= dec_r + 4'd1;
                round_r <= round_r + CNT_W'(1);
            end
        end
    end

    bcd_counter2 u_bcd (
        .clk(KEY),
        .rst_n(rst_n),
        .clr(start_ok),
        .inc(step_ok && !last_dec),
        .units(units),
        .tens(tens)
    );

    assign bus.phase = phase_q;
    assign bus.busy = busy_r;
    assign bus.mode_q = mode_r;
    assign bus.round = round_r;
    assign bus.enc_round = enc_r;
    assign bus.dec_round = dec_r;
    assign bus.round_units = units;
    assign bus.round_tens = tens;
    assign bus.done = done_r;
    assign bus.pass = pass_r;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: randomized self-checking bench against an arithmetic run model.
module tb_aes_round_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    aes_round_sequencer_if #(.CNT_W(5)) bus();
    aes_round_sequencer #(.BASE_ROUNDS(10), .ROUND_STEP(2), .CNT_W(5)) dut (
        .KEY(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Expected {phase, round, enc, dec, tens, units, busy} after k accepted steps of a run.
    function automatic logic [23:0] exp_vec(int m, int k);
        int n = 10 + 2 * (m == 3 ? 0 : m);
        int r = k < 2 * n + 1 ? k : 2 * n + 1;
        int e = k < n ? k : n;
        int d = k <= n + 1 ? 0 : (k - n - 1 < n ? k - n - 1 : n);
        int ph = k <= n ? 1 : (k <= 2 * n + 1 ? 2 : 3);
        return {2'(ph), 5'(r), 4'(e), 4'(d), 4'(r / 10), 4'(r % 10), 1'(ph == 1 || ph == 2)};
    endfunction

    function automatic logic [23:0] obs();
        return {bus.phase, bus.round, bus.enc_round, bus.dec_round, bus.round_tens, bus.round_units, bus.busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.step = 0; bus.mode = 0; bus.dec_match = 0; rst_n = 0;
        repeat (2) tick();
        n_chk++;
        if (obs() !== 24'd0) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs(), 24'd0); end
        n_chk++;
        if ({bus.done, bus.pass, bus.mode_q} !== 4'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.done, bus.pass, bus.mode_q}); end
        rst_n = 1;
        tick();
        n_chk++;
        if (obs() !== 24'd0) begin n_fail++; $display("FAIL reset_idle: got %h want %h", obs(), 24'd0); end
    endtask

    task automatic test_basic();
        bus.mode = 0; bus.dec_match = 1; bus.start = 1;
        tick();
        bus.start = 0;
        n_chk++;
        if (obs() !== exp_vec(0, 0)) begin n_fail++; $display("FAIL basic_start: got %h want %h", obs(), exp_vec(0, 0)); end
        for (int s = 1; s <= 22; s++) begin
            bus.step = 1;
            tick();
            bus.step = 0;
            n_chk++;
            if (obs() !== exp_vec(0, s)) begin n_fail++; $display("FAIL basic_step%0d: got %h want %h", s, obs(), exp_vec(0, s)); end
            n_chk++;
            if (bus.done !== 1'(s == 22)) begin n_fail++; $display("FAIL basic_done%0d: got %b want %b", s, bus.done, s == 22); end
            repeat ($urandom_range(0, 2)) tick();
            n_chk++;
            if (obs() !== exp_vec(0, s)) begin n_fail++; $display("FAIL basic_hold%0d: got %h want %h", s, obs(), exp_vec(0, s)); end
        end
        tick();
        n_chk++;
        if ({bus.done, bus.pass} !== 2'b01) begin n_fail++; $display("FAIL basic_end: got done/pass %b want 01", {bus.done, bus.pass}); end
    endtask

    task automatic test_back_to_back();
        logic dm = 0;
        bus.mode = 2; bus.start = 1;
        tick();
        bus.start = 0;
        for (int s = 1; s <= 30; s++) begin
            bus.step = 1;
            bus.dec_match = 1'($urandom % 2);
            dm = bus.dec_match;
            tick();
            n_chk++;
            if (obs() !== exp_vec(2, s)) begin n_fail++; $display("FAIL b2b_step%0d: got %h want %h", s, obs(), exp_vec(2, s)); end
        end
        n_chk++;
        if ({bus.done, bus.pass} !== {1'b1, dm}) begin n_fail++; $display("FAIL b2b_final: got done/pass %b want %b", {bus.done, bus.pass}, {1'b1, dm}); end
        bus.dec_match = ~dm;
        tick();
        n_chk++;
        if ({obs(), bus.done, bus.pass} !== {exp_vec(2, 30), 1'b0, dm}) begin n_fail++; $display("FAIL b2b_done_hold: got %h want %h", {obs(), bus.done, bus.pass}, {exp_vec(2, 30), 1'b0, dm}); end
        bus.step = 0;
    endtask

    task automatic test_mode3();
        bus.mode = 3; bus.start = 1;
        tick();
        bus.start = 0;
        n_chk++;
        if (bus.mode_q !== 2'd0) begin n_fail++; $display("FAIL mode3_map: got %0d want 0", bus.mode_q); end
        for (int s = 1; s <= 22; s++) begin
            if (s == 6) bus.mode = 2;
            bus.step = 1;
            tick();
            n_chk++;
            if (obs() !== exp_vec(3, s)) begin n_fail++; $display("FAIL mode3_step%0d: got %h want %h", s, obs(), exp_vec(3, s)); end
        end
        bus.step = 0;
    endtask

    task automatic test_random();
        for (int run = 0; run < 6; run++) begin
            int m = $urandom_range(0, 3);
            int k = 0;
            int tot = 2 * (10 + 2 * (m == 3 ? 0 : m)) + 2;
            logic pe = 0;
            logic fin;
            bus.mode = 2'(m); bus.start = 1; bus.step = 1'($urandom % 2);
            tick();
            bus.start = 0;
            n_chk++;
            if ({obs(), bus.mode_q} !== {exp_vec(m, 0), 2'(m == 3 ? 0 : m)}) begin n_fail++; $display("FAIL rnd_start%0d: got %h want %h", run, {obs(), bus.mode_q}, {exp_vec(m, 0), 2'(m == 3 ? 0 : m)}); end
            for (int c = 0; c < 400 && k < tot; c++) begin
                bus.step = 1'($urandom % 2);
                bus.start = ($urandom % 8) == 0;
                bus.mode = 2'($urandom % 4);
                bus.dec_match = 1'($urandom % 2);
                if (bus.step) k++;
                fin = bus.step && k == tot;
                if (fin) pe = bus.dec_match;
                tick();
                n_chk++;
                if ({obs(), bus.done} !== {exp_vec(m, k), fin}) begin n_fail++; $display("FAIL rnd%0d_k%0d: got %h want %h", run, k, {obs(), bus.done}, {exp_vec(m, k), fin}); end
            end
            n_chk++;
            if (k < tot) begin n_fail++; $display("FAIL rnd%0d_timeout: got %0d steps want %0d", run, k, tot); end
            bus.start = 0; bus.step = 1; bus.dec_match = ~pe;
            tick();
            n_chk++;
            if ({obs(), bus.pass} !== {exp_vec(m, tot), pe}) begin n_fail++; $display("FAIL rnd%0d_hold: got %h want %h", run, {obs(), bus.pass}, {exp_vec(m, tot), pe}); end
        end
        bus.step = 0;
    endtask

    task automatic test_async_reset();
        bus.mode = 1; bus.start = 1;
        tick();
        bus.start = 0; bus.step = 1;
        repeat (7) tick();
        bus.step = 0;
        n_chk++;
        if (obs() !== exp_vec(1, 7)) begin n_fail++; $display("FAIL arst_pre: got %h want %h", obs(), exp_vec(1, 7)); end
        #2 rst_n = 0;
        #1;
        n_chk++;
        if ({obs(), bus.done, bus.pass, bus.mode_q} !== 28'd0) begin n_fail++; $display("FAIL arst_clear: got %h want 0", {obs(), bus.done, bus.pass, bus.mode_q}); end
        #2 rst_n = 1;
        bus.mode = 0; bus.start = 1;
        tick();
        bus.start = 0;
        n_chk++;
        if (obs() !== exp_vec(0, 0)) begin n_fail++; $display("FAIL arst_restart: got %h want %h", obs(), exp_vec(0, 0)); end
    endtask

`ifdef AES_SEQ_AUTORUN_EN
    task automatic test_autorun();
        int cyc = 0;
        bus.step = 0; bus.mode = 1; bus.dec_match = 0; bus.start = 1;
        tick();
        bus.start = 0;
        while (!bus.done && cyc < 300) begin
            tick();
            cyc++;
        end
        n_chk++;
        if (cyc !== 104) begin n_fail++; $display("FAIL auto_latency: got %0d want 104", cyc); end
        n_chk++;
        if ({bus.round, bus.pass} !== {5'd25, 1'b0}) begin n_fail++; $display("FAIL auto_final: got round %0d pass %b want 25 0", bus.round, bus.pass); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_mode3();
        test_random();
        test_async_reset();
`ifdef AES_SEQ_AUTORUN_EN
        test_autorun();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
